// File: rtl/if_pkg.sv
// -----------------------------------------------------------------------------
// if_pkg
// Shared types and constants for the instruction-fetch stage.
//   if_state_t : fetch FSM states (request, wait for response, hold under
//                freeze, drain a response orphaned by a redirect)
//   NOP_INSTR  : word presented to IF_to_ID when no real instruction is valid
//   PC_STEP    : byte distance between consecutive instructions
// -----------------------------------------------------------------------------
`ifndef WORD_LEN
`define WORD_LEN 32
`endif

package if_pkg;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } if_state_t;

    localparam int unsigned NOP_INSTR = 0;
    localparam int unsigned PC_STEP   = 4;

endpackage

// File: rtl/if_stage_pc_reg.sv
// -----------------------------------------------------------------------------
// pc_reg
// Program counter register for the fetch stage.
//   clk      : rising-edge clock
//   rst      : asynchronous active-low reset, loads RESET_PC
//   load     : take load_val (branch redirect); wins over advance
//   load_val : redirect address, already word aligned by the caller
//   advance  : step to the next sequential instruction (modulo 2^WORD_LEN)
//   pc       : current fetch address
// -----------------------------------------------------------------------------
module pc_reg
    import if_pkg::*;
#(
    parameter int                  WORD_LEN = `WORD_LEN,
    parameter logic [WORD_LEN-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [WORD_LEN-1:0] load_val,
    input  logic                advance,
    output logic [WORD_LEN-1:0] pc
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_val;
        end else if (advance) begin
            pc <= pc + WORD_LEN'(PC_STEP);
        end
    end

endmodule

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage
// Instruction-fetch stage: owns the PC, issues one instruction-memory request
// at a time and presents each returned word, registered, to IF_to_ID.
//   clk, rst        : clock, asynchronous active-low reset
//   freeze          : hazard stall, holds a delivered instruction and the PC
//   branch_taken    : redirect strobe from a later stage
//   branch_target   : redirect address (low two bits ignored)
//   imem_req/addr   : request valid / address (address always equals pc)
//   imem_gnt        : request accepted this cycle
//   imem_rvalid/rdata : response valid / word
//   instruction     : fetched word, NOP when valid is low
//   pc_out          : address of instruction
//   valid           : instruction holds a real fetched word
//   flush           : one-cycle pulse clearing IF_to_ID after a redirect
// -----------------------------------------------------------------------------
module if_stage
    import if_pkg::*;
#(
    parameter int                  WORD_LEN = `WORD_LEN,
    parameter logic [WORD_LEN-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                freeze,
    input  logic                branch_taken,
    input  logic [WORD_LEN-1:0] branch_target,
    output logic                imem_req,
    output logic [WORD_LEN-1:0] imem_addr,
    input  logic                imem_gnt,
    input  logic                imem_rvalid,
    input  logic [WORD_LEN-1:0] imem_rdata,
    output logic [WORD_LEN-1:0] instruction,
    output logic [WORD_LEN-1:0] pc_out,
    output logic                valid,
    output logic                flush
);

    if_state_t           state;
    logic                active;
    logic [WORD_LEN-1:0] pc;
    logic [WORD_LEN-1:0] aligned_target;
    logic                grant_fire;
    logic                advance;
    logic                in_flight_after;

    // active is a registered "out of reset" flag so imem_req stays low during
    // reset without decoding the reset pin combinationally.
    assign imem_req  = active && (state == S_REQ);
    assign imem_addr = pc;

    assign grant_fire     = imem_req && imem_gnt;
    assign aligned_target = branch_target & ~WORD_LEN'(PC_STEP - 1);

    assign advance = ((state == S_WAIT) && imem_rvalid && !freeze) ||
                     ((state == S_HOLD) && !freeze);

    // A request is still owed a response after this edge if it was just
    // granted, or if we are waiting and the response did not arrive now.
    // A response landing in the same cycle as a redirect retires the request,
    // so there is nothing left to drain.
    assign in_flight_after = ((state == S_REQ) && grant_fire) ||
                             (((state == S_WAIT) || (state == S_DRAIN)) && !imem_rvalid);

    pc_reg #(
        .WORD_LEN (WORD_LEN),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (branch_taken),
        .load_val (aligned_target),
        .advance  (advance),
        .pc       (pc)
    );

    // Fetch FSM with registered IF_to_ID outputs; a redirect pre-empts
    // every other transition, including a response arriving this cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_REQ;
            active      <= 1'b0;
            instruction <= WORD_LEN'(NOP_INSTR);
            pc_out      <= '0;
            valid       <= 1'b0;
            flush       <= 1'b0;
        end else begin
            active <= 1'b1;
            flush  <= branch_taken;
            if (branch_taken) begin
                valid       <= 1'b0;
                instruction <= WORD_LEN'(NOP_INSTR);
                state       <= in_flight_after ? S_DRAIN : S_REQ;
            end else begin
                case (state)
                    S_REQ: begin
                        valid       <= 1'b0;
                        instruction <= WORD_LEN'(NOP_INSTR);
                        if (grant_fire) begin
                            state <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (imem_rvalid) begin
                            instruction <= imem_rdata;
                            pc_out      <= pc;
                            valid       <= 1'b1;
                            state       <= freeze ? S_HOLD : S_REQ;
                        end else begin
                            valid       <= 1'b0;
                            instruction <= WORD_LEN'(NOP_INSTR);
                        end
                    end
                    S_HOLD: begin
                        if (!freeze) begin
                            valid       <= 1'b0;
                            instruction <= WORD_LEN'(NOP_INSTR);
                            state       <= S_REQ;
                        end
                    end
                    S_DRAIN: begin
                        valid       <= 1'b0;
                        instruction <= WORD_LEN'(NOP_INSTR);
                        if (imem_rvalid) begin
                            state <= S_REQ;
                        end
                    end
                    default: begin
                        state <= S_REQ;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage
// Directed scenarios followed by randomized fetches for if_stage. The bench
// plays the instruction memory and tracks the expected fetch address with
// plain 32-bit arithmetic (sequential +4, redirects aligned down to a word).
// -----------------------------------------------------------------------------
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [31:0] pc_out;
    logic        valid;
    logic        flush;

    int          pass_count  = 0;
    int          check_count = 0;
    logic [31:0] exp_pc;

    if_stage #(
        .WORD_LEN (32),
        .RESET_PC (32'h0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .freeze        (freeze),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .instruction   (instruction),
        .pc_out        (pc_out),
        .valid         (valid),
        .flush         (flush)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic gnt, input logic rv, input logic [31:0] data,
                                 input logic frz, input logic br, input logic [31:0] tgt);
        imem_gnt      = gnt;
        imem_rvalid   = rv;
        imem_rdata    = data;
        freeze        = frz;
        branch_taken  = br;
        branch_target = tgt;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic waitReq();
        int n;
        n = 0;
        while (!imem_req && n < 20) begin
            step();
            n++;
        end
        if (!imem_req) checkOutput("req_timeout", {31'd0, imem_req}, 32'd1);
    endtask

    // One complete fetch: optional grant delay, response latency, optional
    // freeze at delivery. Checks the request address, the single-outstanding
    // rule, the delivered word and the next sequential request.
    task automatic serve(input int gw, input int rw, input logic [31:0] data,
                         input logic frz, input int frz_cycles, input logic [31:0] want);
        logic [31:0] nxt;
        nxt = want + 32'd4;
        waitReq();
        checkOutput("req_addr", imem_addr, want);
        for (int i = 0; i < gw; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
            step();
            checkOutput("req_held", {31'd0, imem_req}, 32'd1);
        end
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step();
        checkOutput("one_outstanding", {31'd0, imem_req}, 32'd0);
        for (int i = 1; i < rw; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
            step();
            checkOutput("one_outstanding", {31'd0, imem_req}, 32'd0);
            checkOutput("wait_bubble", {31'd0, valid}, 32'd0);
        end
        applyStimulus(1'b0, 1'b1, data, frz, 1'b0, 32'h0);
        step();
        checkOutput("deliver_valid", {31'd0, valid}, 32'd1);
        checkOutput("deliver_instr", instruction, data);
        checkOutput("deliver_pc_out", pc_out, want);
        if (frz) begin
            for (int i = 0; i < frz_cycles; i++) begin
                applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
                step();
                checkOutput("hold_valid", {31'd0, valid}, 32'd1);
                checkOutput("hold_instr", instruction, data);
                checkOutput("hold_no_req", {31'd0, imem_req}, 32'd0);
                checkOutput("hold_pc", imem_addr, want);
            end
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
            step();
            checkOutput("release_valid", {31'd0, valid}, 32'd0);
        end
        checkOutput("next_req", {31'd0, imem_req}, 32'd1);
        checkOutput("next_addr", imem_addr, nxt);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        exp_pc = nxt;
    endtask

    // Redirect issued while idle in the request state (no grant this cycle).
    task automatic idleBranch(input logic [31:0] tgt);
        logic [31:0] aligned;
        aligned = tgt & 32'hFFFF_FFFC;
        waitReq();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, tgt);
        step();
        checkOutput("br_flush", {31'd0, flush}, 32'd1);
        checkOutput("br_valid", {31'd0, valid}, 32'd0);
        checkOutput("br_addr", imem_addr, aligned);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        exp_pc = aligned;
    endtask

    initial begin
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step();
        step();
        checkOutput("rst_req", {31'd0, imem_req}, 32'd0);
        checkOutput("rst_valid", {31'd0, valid}, 32'd0);
        checkOutput("rst_instr", instruction, 32'h0);
        checkOutput("rst_pc_out", pc_out, 32'h0);
        checkOutput("rst_flush", {31'd0, flush}, 32'd0);
        checkOutput("rst_addr", imem_addr, 32'h0);
        #2 rst = 1'b1;
        step();

        $display("[TB] reset and first fetch");
        serve(0, 1, 32'h0000_0013, 1'b0, 0, 32'h0);

        $display("[TB] freeze hold");
        serve(0, 1, 32'h0000_00AA, 1'b1, 5, exp_pc);

        $display("[TB] redirect while waiting");
        waitReq();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0103);
        step();
        checkOutput("rw_flush", {31'd0, flush}, 32'd1);
        checkOutput("rw_valid", {31'd0, valid}, 32'd0);
        checkOutput("rw_no_req", {31'd0, imem_req}, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step();
        checkOutput("rw_flush_end", {31'd0, flush}, 32'd0);
        applyStimulus(1'b0, 1'b1, 32'h0000_00BB, 1'b0, 1'b0, 32'h0);
        step();
        checkOutput("rw_drop_valid", {31'd0, valid}, 32'd0);
        checkOutput("rw_drop_instr", instruction, 32'h0);
        checkOutput("rw_req", {31'd0, imem_req}, 32'd1);
        checkOutput("rw_addr", imem_addr, 32'h0000_0100);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        exp_pc = 32'h0000_0100;

        $display("[TB] branch beats response");
        waitReq();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step();
        applyStimulus(1'b0, 1'b1, 32'h0000_00CC, 1'b1, 1'b1, 32'h0000_0040);
        step();
        checkOutput("bb_valid", {31'd0, valid}, 32'd0);
        checkOutput("bb_instr", instruction, 32'h0);
        checkOutput("bb_flush", {31'd0, flush}, 32'd1);
        checkOutput("bb_req", {31'd0, imem_req}, 32'd1);
        checkOutput("bb_addr", imem_addr, 32'h0000_0040);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step();
        checkOutput("bb_flush_end", {31'd0, flush}, 32'd0);

        $display("[TB] back-to-back branches and pc wrap");
        idleBranch(32'h0000_0080);
        idleBranch(32'hFFFF_FFFF);
        step();
        checkOutput("b2b_flush_end", {31'd0, flush}, 32'd0);
        serve(1, 2, 32'h1234_5678, 1'b0, 0, exp_pc);
        checkOutput("wrap_addr", imem_addr, 32'h0);

        $display("[TB] reset mid-operation");
        idleBranch(32'h0000_0020);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #2 rst = 1'b0;
        #1;
        checkOutput("mid_rst_req", {31'd0, imem_req}, 32'd0);
        checkOutput("mid_rst_addr", imem_addr, 32'h0);
        checkOutput("mid_rst_pc_out", pc_out, 32'h0);
        checkOutput("mid_rst_valid", {31'd0, valid}, 32'd0);
        checkOutput("mid_rst_flush", {31'd0, flush}, 32'd0);
        step();
        rst = 1'b1;
        applyStimulus(1'b0, 1'b1, 32'h0000_00DD, 1'b0, 1'b0, 32'h0);
        step();
        checkOutput("stale_valid", {31'd0, valid}, 32'd0);
        checkOutput("stale_instr", instruction, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        serve(0, 1, 32'h0BAD_F00D, 1'b0, 0, 32'h0);

        $display("[TB] randomized fetches");
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 4) == 0) idleBranch($urandom);
            serve(int'($urandom_range(0, 3)), int'($urandom_range(1, 3)), $urandom,
                  ($urandom_range(0, 3) == 0), int'($urandom_range(1, 4)), exp_pc);
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks %0d", check_count);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
